// File: rtl/poker_pkg.sv
// poker_pkg: shared constants, card type, loader state encoding and the
// card-to-deck-index helper used by card_frame_loader and card_dup_mask.
package poker_pkg;

  localparam int unsigned NUM_PLAYERS     = 9;
  localparam int unsigned HOLE_PER_PLAYER = 2;
  localparam int unsigned PUB_CARDS       = 3;
  localparam int unsigned HOLE_CARDS      = NUM_PLAYERS * HOLE_PER_PLAYER;
  localparam int unsigned FRAME_CARDS     = HOLE_CARDS + PUB_CARDS;
  localparam int unsigned DECK_CARDS      = 52;

  // Default legal rank window (ace = 14).
  localparam int unsigned RANK_MIN_DEF = 2;
  localparam int unsigned RANK_MAX_DEF = 14;

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] suit;
  } card_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_EMIT    = 2'd2
  } loader_state_e;

  // Deck position (rank-rank_min)*4+suit. Ranks below rank_min wrap to a
  // large offset, so any out-of-window rank lands at index >= 52.
  function automatic logic [5:0] card_index(card_t c, logic [3:0] rank_min);
    logic [3:0] rank_off;
    rank_off = c.num - rank_min;
    return {rank_off, c.suit};
  endfunction

endpackage

// File: rtl/card_frame_loader_if.sv
// card_frame_loader_if: card stream in, frame bundle out, core busy back.
// master = upstream source / win-rate core side, slave = the loader.
interface card_frame_loader_if;
  import poker_pkg::*;

  // Card stream
  logic                      in_valid;
  logic [3:0]                in_num;
  logic [1:0]                in_suit;
  logic                      in_ready;

  // Core side
  logic                      core_busy;
  logic                      out_valid;
  logic [4*HOLE_CARDS-1:0]   out_hole_num;
  logic [2*HOLE_CARDS-1:0]   out_hole_suit;
  logic [4*PUB_CARDS-1:0]    out_pub_num;
  logic [2*PUB_CARDS-1:0]    out_pub_suit;
  logic                      out_err;

  modport master (
    output in_valid, in_num, in_suit, core_busy,
    input  in_ready, out_valid, out_hole_num, out_hole_suit,
           out_pub_num, out_pub_suit, out_err
  );

  modport slave (
    input  in_valid, in_num, in_suit, core_busy,
    output in_ready, out_valid, out_hole_num, out_hole_suit,
           out_pub_num, out_pub_suit, out_err
  );

endinterface

// File: rtl/card_dup_mask.sv
// card_dup_mask: 52-bit used-card mask for the loader's duplicate check.
// Only built when CARD_DUP_CHECK_EN is defined. o_hit reflects the
// registered mask for i_index; indices >= 52 never hit and never set.
`ifdef CARD_DUP_CHECK_EN
module card_dup_mask
  import poker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_set,
  input  logic [5:0] i_index,
  output logic       o_hit
);

  logic [DECK_CARDS-1:0] r_mask;
  logic                  w_in_deck;

  assign w_in_deck = (i_index < 6'(DECK_CARDS));
  assign o_hit     = w_in_deck & r_mask[i_index];

  // Mask update: clear wins over set so an aborted/issued frame starts empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (i_clear) begin
      r_mask <= '0;
    end else if (i_set && w_in_deck) begin
      r_mask[i_index] <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/card_frame_loader.sv
// card_frame_loader: collects 21 cards (18 hole, then 3 flop) from a
// one-card-per-cycle stream, range-checks each card, and issues the frame
// as a one-cycle parallel bundle once the win-rate core is idle.
// Optional feature: define CARD_DUP_CHECK_EN to add duplicate-card abort.
module card_frame_loader
  import poker_pkg::*;
#(
  parameter int unsigned RANK_MIN = RANK_MIN_DEF,
  parameter int unsigned RANK_MAX = RANK_MAX_DEF
) (
  input logic                clk,
  input logic                rst_n,
  card_frame_loader_if.slave bus
);

  localparam logic [3:0] RANK_MIN_C = 4'(RANK_MIN);
  localparam logic [3:0] RANK_MAX_C = 4'(RANK_MAX);
  localparam logic [4:0] LAST_K     = 5'(FRAME_CARDS - 1);
  localparam logic [4:0] HOLE_K     = 5'(HOLE_CARDS);

  loader_state_e           r_state;
  logic [4:0]              r_k;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_out_err;

  logic [4*HOLE_CARDS-1:0] r_hole_num;
  logic [2*HOLE_CARDS-1:0] r_hole_suit;
  logic [4*PUB_CARDS-1:0]  r_pub_num;
  logic [2*PUB_CARDS-1:0]  r_pub_suit;

  card_t                   w_card;
  logic                    w_accept;
  logic                    w_range_bad;
  logic                    w_dup;
  logic                    w_bad;
  logic                    w_write;
  logic [1:0]              w_pub_idx;

  assign w_card      = '{num: bus.in_num, suit: bus.in_suit};
  // Cards offered outside COLLECT are simply not taken.
  assign w_accept    = bus.in_valid && (r_state == ST_COLLECT);
  assign w_range_bad = (w_card.num < RANK_MIN_C) || (w_card.num > RANK_MAX_C);
  // Range and duplicate faults merge into one abort, so one out_err.
  assign w_bad       = w_range_bad | w_dup;
  assign w_write     = w_accept & ~w_bad;
  assign w_pub_idx   = 2'(r_k - HOLE_K);

`ifdef CARD_DUP_CHECK_EN
  logic       w_mask_clear;
  logic       w_mask_set;
  logic [5:0] w_card_idx;
  logic       w_dup_hit;

  assign w_card_idx   = card_index(w_card, RANK_MIN_C);
  assign w_mask_clear = (r_state == ST_EMIT) | (w_accept & w_bad);
  assign w_mask_set   = w_write;
  assign w_dup        = w_dup_hit;

  card_dup_mask u_dup_mask (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_mask_clear),
    .i_set   (w_mask_set),
    .i_index (w_card_idx),
    .o_hit   (w_dup_hit)
  );
`else
  // No mask: a repeated card is just another card.
  assign w_dup = 1'b0;
`endif

  // Loader FSM: COLLECT -> HOLD -> EMIT -> COLLECT with registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block sampling the pre-edge values, independent of statement order.
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (w_bad) begin
              // Abort: source restarts the whole frame from card 0.
              r_out_err <= 1'b1;
              r_k       <= '0;
            end else if (r_k == LAST_K) begin
              r_state    <= ST_HOLD;
              r_in_ready <= 1'b0;
            end else begin
              r_k <= r_k + 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.core_busy) begin
            r_state     <= ST_EMIT;
            r_out_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          // Busy rising now is the core reacting to this strobe; not a cancel.
          r_state    <= ST_COLLECT;
          r_in_ready <= 1'b1;
          r_k        <= '0;
        end
        default: begin
          r_state    <= ST_COLLECT;
          r_in_ready <= 1'b1;
          r_k        <= '0;
        end
      endcase
    end
  end

  // Frame storage: accepted good card goes to hole slot k or flop slot k-18.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the frame storage is small, so it is reset like any other
      // register rather than being left uninitialised as a RAM would be.
      r_hole_num  <= '0;
      r_hole_suit <= '0;
      r_pub_num   <= '0;
      r_pub_suit  <= '0;
    end else if (w_write) begin
      if (r_k < HOLE_K) begin
        r_hole_num[{r_k, 2'b00} +: 4]  <= w_card.num;
        r_hole_suit[{r_k, 1'b0} +: 2]  <= w_card.suit;
      end else begin
        r_pub_num[{w_pub_idx, 2'b00} +: 4] <= w_card.num;
        r_pub_suit[{w_pub_idx, 1'b0} +: 2] <= w_card.suit;
      end
    end
  end

  // Bundle is visible only during the strobe cycle; zero otherwise.
  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_err       = r_out_err;
  assign bus.out_hole_num  = r_out_valid ? r_hole_num  : '0;
  assign bus.out_hole_suit = r_out_valid ? r_hole_suit : '0;
  assign bus.out_pub_num   = r_out_valid ? r_pub_num   : '0;
  assign bus.out_pub_suit  = r_out_valid ? r_pub_suit  : '0;

endmodule

// File: tb/tb_card_frame_loader.sv
// tb_card_frame_loader: randomized stimulus with a queue-based reference
// model; a negedge monitor pops expected frames/aborts and compares.
module tb_card_frame_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  card_frame_loader_if bus();

  card_frame_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] suit;
  } tc_t;

  typedef struct {
    bit          is_err;
    logic [71:0] hn;
    logic [35:0] hs;
    logic [11:0] pn;
    logic [5:0]  ps;
  } exp_t;

  tc_t  frame_q[$];
  exp_t exp_q[$];
  tc_t  cur[21];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of accepted cards; a bad card empties
  // the list and produces an abort; the 21st card produces a bundle.
  function automatic bit model_card(tc_t c);
    bit   bad;
    exp_t e;
    bad = (c.num < 2) || (c.num > 14);
`ifdef CARD_DUP_CHECK_EN
    foreach (frame_q[i]) if (frame_q[i] == c) bad = 1'b1;
`endif
    e.is_err = 1'b0; e.hn = '0; e.hs = '0; e.pn = '0; e.ps = '0;
    if (bad) begin
      e.is_err = 1'b1;
      exp_q.push_back(e);
      frame_q.delete();
      return 1'b1;
    end
    frame_q.push_back(c);
    if (frame_q.size() == 21) begin
      for (int i = 0; i < 18; i++) begin
        e.hn[4*i +: 4] = frame_q[i].num;
        e.hs[2*i +: 2] = frame_q[i].suit;
      end
      for (int j = 0; j < 3; j++) begin
        e.pn[4*j +: 4] = frame_q[18+j].num;
        e.ps[2*j +: 2] = frame_q[18+j].suit;
      end
      exp_q.push_back(e);
      frame_q.delete();
    end
    return 1'b0;
  endfunction

  // Monitor: compares every strobe against the scoreboard, idle bundle = 0.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid || bus.out_err) begin
        check("valid_err_exclusive", 128'(bus.out_valid & bus.out_err), 128'(0));
        check("strobe_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_kind_err", 128'(bus.out_err), 128'(e.is_err));
          check("hole_num", 128'(bus.out_hole_num), 128'(e.hn));
          check("hole_suit", 128'(bus.out_hole_suit), 128'(e.hs));
          check("pub_num", 128'(bus.out_pub_num), 128'(e.pn));
          check("pub_suit", 128'(bus.out_pub_suit), 128'(e.ps));
        end
      end else begin
        check("idle_bundle_zero",
              128'({bus.out_hole_num, bus.out_hole_suit, bus.out_pub_num, bus.out_pub_suit}),
              128'(0));
      end
    end
  end

  // Stimulus helpers
  task automatic junk();
    bus.in_valid = 1'($urandom_range(1, 0));
    bus.in_num   = 4'($urandom);
    bus.in_suit  = 2'($urandom);
  endtask

  task automatic make_deck();
    tc_t deck[52];
    tc_t t;
    int  j;
    for (int i = 0; i < 52; i++) deck[i] = '{num: 4'(2 + i / 4), suit: 2'(i % 4)};
    for (int i = 51; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = deck[i]; deck[i] = deck[j]; deck[j] = t;
    end
    for (int i = 0; i < 21; i++) cur[i] = deck[i];
  endtask

  // Put card c at position pos while keeping the frame distinct.
  task automatic place_card(input int pos, input tc_t c);
    int found;
    found = -1;
    for (int i = 0; i < 21; i++) if (cur[i] == c) found = i;
    if (found >= 0) cur[found] = cur[pos];
    cur[pos] = c;
  endtask

  task automatic send_card(input tc_t c, output bit aborted);
    repeat ($urandom_range(2, 0)) begin
      @(posedge clk); #1;
    end
    check("in_ready_collect", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_num   = c.num;
    bus.in_suit  = c.suit;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    aborted = model_card(c);
    if (aborted) check("err_next_cycle", 128'(bus.out_err), 128'(1));
  endtask

  task automatic send_frame(input int busy, output bit aborted);
    bit ab;
    for (int k = 0; k < 21; k++) begin
      send_card(cur[k], ab);
      if (ab) begin
        aborted = 1'b1;
        return;
      end
    end
    aborted = 1'b0;
    bus.core_busy = (busy > 0);
    check("hold_in_ready", 128'(bus.in_ready), 128'(0));
    check("hold_no_valid", 128'(bus.out_valid), 128'(0));
    for (int c = 0; c < busy; c++) begin
      junk();
      @(posedge clk); #1;
      check("busy_in_ready", 128'(bus.in_ready), 128'(0));
      check("busy_no_valid", 128'(bus.out_valid), 128'(0));
    end
    bus.core_busy = 1'b0;
    junk();
    @(posedge clk); #1;
    check("emit_valid", 128'(bus.out_valid), 128'(1));
    check("emit_in_ready", 128'(bus.in_ready), 128'(0));
    bus.core_busy = 1'($urandom_range(1, 0));
    junk();
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.core_busy = 1'b0;
    check("emit_one_cycle", 128'(bus.out_valid), 128'(0));
    check("back_to_collect", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_out_err"}, 128'(bus.out_err), 128'(0));
    check({tag, "_bundle"},
          128'({bus.out_hole_num, bus.out_hole_suit, bus.out_pub_num, bus.out_pub_suit}),
          128'(0));
  endtask

  initial begin
    bit  ab;
    int  k1;
    int  k2;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_suit   = '0;
    bus.core_busy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1. Clean frame with hole card 0 = ace of suit 3.
    make_deck();
    place_card(0, '{num: 4'd14, suit: 2'd3});
    send_frame(0, ab);

    // 2. Core busy for 40 cycles after the frame completes.
    make_deck();
    send_frame(40, ab);

    // 3. Rank 15 at k=5 aborts; a clean frame follows.
    make_deck();
    cur[5].num = 4'd15;
    send_frame(0, ab);
    make_deck();
    send_frame(0, ab);

    // 4. Card k=19 repeats card k=2 = (7,1).
    make_deck();
    place_card(2, '{num: 4'd7, suit: 2'd1});
    cur[19] = '{num: 4'd7, suit: 2'd1};
    send_frame(0, ab);

    // 5. Reset after 10 cards, then the same cards as a fresh frame.
    make_deck();
    for (int k = 0; k < 10; k++) send_card(cur[k], ab);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    frame_q.delete();
    send_frame(0, ab);

    // 6. Random frames: gaps, busy, junk during hold, injected faults.
    for (int f = 0; f < 20; f++) begin
      make_deck();
      if ($urandom_range(3, 0) == 0) begin
        k1 = int'($urandom_range(20, 0));
        case ($urandom_range(2, 0))
          0:       cur[k1].num = 4'd0;
          1:       cur[k1].num = 4'd1;
          default: cur[k1].num = 4'd15;
        endcase
      end
      if ($urandom_range(3, 0) == 0) begin
        k1 = int'($urandom_range(19, 0));
        k2 = int'($urandom_range(20, k1 + 1));
        cur[k2] = cur[k1];
      end
      send_frame(int'($urandom_range(6, 0)), ab);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
